inst_fetch_buffer: RTL



---
 rtl/inst_fetch_buffer.sv | 113 +++++++++++
 1 files changed

// File: rtl/inst_fetch_buffer.sv
// ---------------------------------------------------------------------------
// inst_fetch_buffer
//
// Decoupling FIFO between fetch (PC register + instruction memory) and decode.
// Each accepted {pc, inst} pair is stored in a circular buffer and presented
// to decode through a valid/ready handshake. Occupancy drives a stall back to
// the PC register early enough to cover the one-cycle fetch latency, and a
// flush discards everything buffered so decode never sees wrong-path code.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset, outranks flush and handshakes
//   flush_i      branch taken / pipeline flush, empties the buffer
//   if_valid_i   fetch offers an instruction this cycle
//   if_pc_i      PC of the offered instruction
//   if_inst_i    offered instruction word
//   stall_o      hold the PC register (occupancy at/above STALL_THRESH)
//   full_o       buffer holds DEPTH entries
//   id_valid_o   head entry is valid for decode
//   id_pc_o      PC of head entry (zero when empty)
//   id_inst_o    instruction of head entry (zero when empty)
//   id_ready_i   decode accepts the head entry this cycle
//   count_o      current occupancy
// ---------------------------------------------------------------------------
module inst_fetch_buffer #(
    parameter int DEPTH        = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STALL_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     if_valid_i,
    input  logic [ADDR_WIDTH-1:0]    if_pc_i,
    input  logic [DATA_WIDTH-1:0]    if_inst_i,
    output logic                     stall_o,
    output logic                     full_o,
    output logic                     id_valid_o,
    output logic [ADDR_WIDTH-1:0]    id_pc_o,
    output logic [DATA_WIDTH-1:0]    id_inst_o,
    input  logic                     id_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] r_pcMem   [DEPTH];
    logic [DATA_WIDTH-1:0] r_instMem [DEPTH];
    logic [PTR_W-1:0]      r_wp;
    logic [PTR_W-1:0]      r_rp;
    logic [CNT_W-1:0]      r_cnt;

    logic w_push;
    logic w_pop;
    logic w_notEmpty;

    // Handshake qualification. A full buffer refuses a push even when a pop
    // frees a slot in the same cycle, and flush suppresses both sides.
    always_comb begin
        w_notEmpty = (r_cnt != '0);
        w_push     = if_valid_i && !full_o && !flush_i;
        w_pop      = w_notEmpty && id_ready_i && !flush_i;
    end

    // Pointer and occupancy state. Pointers wrap naturally because DEPTH is
    // a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (flush_i) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTR_W'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_W'(1);
            end
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage array; contents are don't-care after reset since the counter
    // gates every read, so no reset is applied here.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_pcMem[r_wp]   <= if_pc_i;
            r_instMem[r_wp] <= if_inst_i;
        end
    end

    // Outputs are pure functions of state, except stall which is released
    // during a flush so the branch target can load into the PC.
    always_comb begin
        id_valid_o = w_notEmpty;
        id_pc_o    = '0;
        id_inst_o  = '0;
        if (w_notEmpty) begin
            id_pc_o   = r_pcMem[r_rp];
            id_inst_o = r_instMem[r_rp];
        end
        full_o  = (r_cnt == CNT_W'(DEPTH));
        stall_o = (r_cnt >= CNT_W'(STALL_THRESH)) && !flush_i;
        count_o = r_cnt;
    end

endmodule
